// File: rtl/mask_expander.sv
// Expands a stream of packed elements back into their lanes, as given by a lane-occupancy mask.
// Each vector needs one mask, then one din per set mask bit, and it is released on dout.
module mask_expander #(
  parameter int DATA_W = 8,
  parameter int LANES  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mask_valid,
  output logic                    mask_ready,
  input  logic [LANES-1:0]        mask,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic [DATA_W-1:0]       din,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic [LANES*DATA_W-1:0] dout,
  output logic [LANES-1:0]        dout_mask,
  output logic [5:0]              dout_count,
  output logic [1:0]              state_dbg
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1.
  // Every ready and valid output is a registered function of the state only.
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, OUT = 2'd2} state_t;

  state_t           state;
  logic [LANES-1:0] rem_mask;
  logic [LANES-1:0] rem_low;
  logic [LANES-1:0] rem_next;
  logic [5:0]       mask_pop;

  assign state_dbg = state;

  // Isolate the lowest set bit of rem_mask, and the mask that remains once it is cleared.
  assign rem_low  = rem_mask & ~(rem_mask - LANES'(1));
  assign rem_next = rem_mask &  (rem_mask - LANES'(1));

  always_comb begin
    mask_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      mask_pop = mask_pop + 6'(mask[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mask_ready <= 1'b1;
      din_ready  <= 1'b0;
      dout_valid <= 1'b0;
      dout       <= '0;
      dout_mask  <= '0;
      rem_mask   <= '0;
      dout_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mask_valid && mask_ready) begin
            dout_mask  <= mask;
            rem_mask   <= mask;
            dout_count <= mask_pop;
            dout       <= '0;
            mask_ready <= 1'b0;
            if (mask != '0) begin
              state     <= FILL;
              din_ready <= 1'b1;
            end else begin
              state      <= OUT;
              dout_valid <= 1'b1;
            end
          end
        end
        FILL: begin
          if (din_valid && din_ready) begin
            for (int i = 0; i < LANES; i++) begin
              if (rem_low[i]) dout[i*DATA_W +: DATA_W] <= din;
            end
            rem_mask <= rem_next;
            if (rem_next == '0) begin
              state      <= OUT;
              din_ready  <= 1'b0;
              dout_valid <= 1'b1;
            end
          end
        end
        OUT: begin
          if (dout_ready && dout_valid) begin
            state      <= IDLE;
            dout_valid <= 1'b0;
            mask_ready <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          mask_ready <= 1'b1;
          din_ready  <= 1'b0;
          dout_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mask_expander.sv
// Directed and randomized bench for mask_expander.
// The expected vectors are rebuilt from the mask and the queue of sent elements.
module tb_mask_expander;
  localparam int DATA_W = 8;
  localparam int LANES  = 32;
  localparam int VW     = LANES * DATA_W;

  logic              clk;
  logic              reset;
  logic              mask_valid;
  logic              mask_ready;
  logic [LANES-1:0]  mask;
  logic              din_valid;
  logic              din_ready;
  logic [DATA_W-1:0] din;
  logic              dout_valid;
  logic              dout_ready;
  logic [VW-1:0]     dout;
  logic [LANES-1:0]  dout_mask;
  logic [5:0]        dout_count;
  logic [1:0]        state_dbg;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  mask_expander #(.DATA_W(DATA_W), .LANES(LANES)) dut (
    .clk(clk), .reset(reset),
    .mask_valid(mask_valid), .mask_ready(mask_ready), .mask(mask),
    .din_valid(din_valid), .din_ready(din_ready), .din(din),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
    .dout_mask(dout_mask), .dout_count(dout_count), .state_dbg(state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lane i gets the element whose index equals the number of set mask bits below i.
  function automatic logic [VW-1:0] model(input logic [LANES-1:0] m);
    logic [VW-1:0] v;
    int k;
    v = '0;
    k = 0;
    for (int i = 0; i < LANES; i++) begin
      if (m[i]) begin
        v[i*DATA_W +: DATA_W] = exp_q[k];
        k++;
      end
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_mask(input logic [LANES-1:0] m);
    int budget;
    budget = 50;
    while (!mask_ready && budget > 0) begin
      tick();
      budget--;
    end
    check("mask_ready_wait", VW'(mask_ready), VW'(1));
    mask = m;
    mask_valid = 1'b1;
    tick();
    mask_valid = 1'b0;
  endtask

  task automatic send_din(input logic [DATA_W-1:0] d);
    int budget;
    budget = 50;
    din = d;
    din_valid = 1'b1;
    while (!din_ready && budget > 0) begin
      tick();
      budget--;
    end
    check("din_ready_wait", VW'(din_ready), VW'(1));
    tick();
    din_valid = 1'b0;
    exp_q.push_back(d);
  endtask

  task automatic recv(input string tag, input logic [LANES-1:0] m, input int stall);
    int budget;
    logic [VW-1:0] exp_v;
    budget = 50;
    while (!dout_valid && budget > 0) begin
      tick();
      budget--;
    end
    check({tag, "_valid"}, VW'(dout_valid), VW'(1));
    exp_v = model(m);
    repeat (stall) begin
      tick();
      check({tag, "_stall_dout"}, dout, exp_v);
    end
    check({tag, "_dout"}, dout, exp_v);
    check({tag, "_mask"}, VW'(dout_mask), VW'(m));
    check({tag, "_count"}, VW'(dout_count), VW'($countones(m)));
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    check({tag, "_idle"}, VW'({mask_ready, din_ready, dout_valid}), VW'(3'b100));
    exp_q.delete();
  endtask

  initial begin
    logic [LANES-1:0] m;
    logic [VW-1:0]    snap;
    reset = 1'b1;
    mask_valid = 1'b0;
    mask = '0;
    din_valid = 1'b0;
    din = '0;
    dout_ready = 1'b0;
    tick();
    tick();
    check("reset_ctl", VW'({mask_ready, din_ready, dout_valid}), VW'(3'b100));
    check("reset_dout", dout, '0);
    check("reset_cnt", VW'({dout_mask, dout_count, state_dbg}), '0);
    reset = 1'b0;

    // Full mask, back-to-back elements; dout_valid must be visible right after the last din edge.
    send_mask(32'hFFFF_FFFF);
    for (int k = 0; k < 32; k++) begin
      if (k == 31) check("full_not_early", VW'(dout_valid), VW'(0));
      send_din(DATA_W'(k));
    end
    check("full_latency", VW'(dout_valid), VW'(1));
    recv("full", 32'hFFFF_FFFF, 0);

    // Sparse mask.
    send_mask(32'b00001000000010000010000000010011);
    for (int k = 0; k < 6; k++) send_din(DATA_W'(8'hA0 + k));
    recv("sparse", 32'b00001000000010000010000000010011, 0);

    // Empty mask goes straight to OUT.
    send_mask('0);
    check("zero_direct", VW'({din_ready, dout_valid}), VW'(2'b01));
    recv("zero", '0, 0);

    // din_valid toggling on a two-lane mask.
    send_mask(32'h8000_0001);
    din = 8'h11;
    din_valid = 1'b1;
    check("tog_rdy0", VW'(din_ready), VW'(1));
    tick();
    din_valid = 1'b0;
    check("tog_rdy1", VW'(din_ready), VW'(1));
    tick();
    check("tog_rdy2", VW'(din_ready), VW'(1));
    din = 8'h22;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    recv("toggle", 32'h8000_0001, 0);

    // Downstream stall with a competing mask that must be ignored.
    send_mask(32'h0000_F00F);
    for (int k = 0; k < 8; k++) send_din(DATA_W'($urandom));
    snap = model(32'h0000_F00F);
    for (int c = 0; c < 5; c++) begin
      mask = 32'hFFFF_FFFF;
      mask_valid = 1'b1;
      tick();
      check("stall_dout", dout, snap);
      check("stall_ctl", VW'({mask_ready, dout_valid}), VW'(2'b01));
      check("stall_mask", VW'(dout_mask), VW'(32'h0000_F00F));
    end
    mask_valid = 1'b0;
    recv("stall", 32'h0000_F00F, 0);
    check("stall_ignored", VW'(dout_mask), VW'(32'h0000_F00F));

    // Reset in the middle of a fill, checked before any clock edge.
    send_mask(32'h0000_00FF);
    for (int k = 0; k < 3; k++) send_din(DATA_W'(k + 1));
    #2;
    reset = 1'b1;
    #1;
    check("mid_reset_ctl", VW'({mask_ready, din_ready, dout_valid}), VW'(3'b100));
    check("mid_reset_dout", dout, '0);
    check("mid_reset_rest", VW'({dout_mask, dout_count, state_dbg}), '0);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    mask = 32'h1;
    mask_valid = 1'b1;
    tick();
    mask_valid = 1'b0;
    check("post_reset_accept", VW'(din_ready), VW'(1));
    send_din(8'd7);
    recv("post_reset", 32'h1, 0);

    // Randomized vectors with din gaps and output stalls.
    for (int it = 0; it < 20; it++) begin
      m = LANES'($urandom);
      if (it % 4 == 0) m = m & LANES'($urandom) & LANES'($urandom);
      send_mask(m);
      for (int k = 0; k < $countones(m); k++) begin
        din_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
        send_din(DATA_W'($urandom));
      end
      recv("rand", m, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
